// File: rtl/reg_info_bank.sv
// Multi-channel holding register between the RTC and the display formatter.
// It tracks RTC updates, edits one channel in a shadow copy, and writes commits back to the RTC.
module reg_info_bank #(
  parameter int DATA_W  = 48,
  parameter int N_CH    = 3,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              estado,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [CH_W-1:0]   disp_ch,
  input  logic [DATA_W-1:0] dato_user,
  input  logic              user_we,
  input  logic [DATA_W-1:0] dato_rtc,
  input  logic [CH_W-1:0]   rtc_ch,
  input  logic              rtc_valid,
  input  logic              wb_ack,
  output logic              wb_req,
  output logic [CH_W-1:0]   wb_ch,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              wb_err,
  output logic [DATA_W-1:0] almacenamiento
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CH_W:0] LP_NCH = N_CH[CH_W:0];
  localparam logic [CNT_W-1:0] LP_TIMEOUT = TIMEOUT[CNT_W-1:0];

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EDIT = 2'd1, ST_WB = 2'd2} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_bank [N_CH];
  logic [DATA_W-1:0]   r_shadow;
  logic [CH_W-1:0]     r_edit_ch;
  logic                r_dirty;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wb_req;
  logic [CH_W-1:0]     r_wb_ch;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_busy;
  logic                r_wb_err;
  logic [DATA_W-1:0]   r_alm;

  logic                w_sel_ok;
  logic                w_rtc_ok;
  logic                w_disp_ok;
  logic                w_user_wr;
  logic                w_enter;
  logic                w_commit;
  logic                w_ack_ok;
  logic                w_tout;
  logic [DATA_W-1:0]   w_shadow_nxt;
  logic [DATA_W-1:0]   w_alm_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_enter      = 1'b0;
    w_commit     = 1'b0;
    w_ack_ok     = 1'b0;
    w_tout       = 1'b0;
    w_sel_ok     = ({1'b0, ch_sel} < LP_NCH);
    w_disp_ok    = ({1'b0, disp_ch} < LP_NCH);
    // RTC writes to the channel under edit or write-back are dropped
    w_rtc_ok     = rtc_valid && ({1'b0, rtc_ch} < LP_NCH) &&
                   ((r_state == ST_IDLE) || (rtc_ch != r_edit_ch));
    w_user_wr    = (r_state == ST_EDIT) && user_we;
    w_shadow_nxt = w_user_wr ? dato_user : r_shadow;
    case (r_state)
      ST_IDLE: begin
        if (estado && w_sel_ok) begin
          w_state_nxt = ST_EDIT;
          w_enter     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EDIT: begin
        if (!estado) begin
          if (r_dirty || user_we) begin
            w_state_nxt = ST_WB;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_EDIT;
        end
      end
      ST_WB: begin
        if (wb_ack) begin
          w_state_nxt = ST_IDLE;
          w_ack_ok    = 1'b1;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_tout      = 1'b1;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if ((r_state != ST_IDLE) && (disp_ch == r_edit_ch)) begin
      w_alm_nxt = r_shadow;
    end else if (w_disp_ok) begin
      w_alm_nxt = r_bank[disp_ch];
    end else begin
      w_alm_nxt = {DATA_W{1'b0}};
    end
  end

  // Bank, shadow, write-back handshake and display registers
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        r_bank[i] <= {DATA_W{1'b0}};
      end
      r_shadow  <= {DATA_W{1'b0}};
      r_edit_ch <= {CH_W{1'b0}};
      r_dirty   <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_wb_req  <= 1'b0;
      r_wb_ch   <= {CH_W{1'b0}};
      r_wb_data <= {DATA_W{1'b0}};
      r_busy    <= 1'b0;
      r_wb_err  <= 1'b0;
      r_alm     <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_commit && (r_edit_ch == CH_W'(i))) begin
          r_bank[i] <= w_shadow_nxt;
        end else if (w_rtc_ok && (rtc_ch == CH_W'(i))) begin
          r_bank[i] <= dato_rtc;
        end else begin
          r_bank[i] <= r_bank[i];
        end
      end
      if (w_enter) begin
        r_edit_ch <= ch_sel;
        r_shadow  <= r_bank[ch_sel];
        r_dirty   <= 1'b0;
      end else if (w_commit) begin
        r_shadow  <= w_shadow_nxt;
        r_dirty   <= 1'b0;
      end else if (w_user_wr) begin
        r_shadow  <= dato_user;
        r_dirty   <= 1'b1;
      end
      if (w_commit) begin
        r_wb_req  <= 1'b1;
        r_wb_ch   <= r_edit_ch;
        r_wb_data <= w_shadow_nxt;
        r_cnt     <= LP_TIMEOUT;
      end else if (w_ack_ok) begin
        r_wb_req  <= 1'b0;
        r_wb_err  <= 1'b0;
      end else if (w_tout) begin
        r_wb_req  <= 1'b0;
        r_wb_err  <= 1'b1;
      end else if (r_state == ST_WB) begin
        r_cnt     <= r_cnt - CNT_W'(1);
      end
      r_busy <= (w_state_nxt != ST_IDLE);
      r_alm  <= w_alm_nxt;
    end
  end

  assign wb_req         = r_wb_req;
  assign wb_ch          = r_wb_ch;
  assign wb_data        = r_wb_data;
  assign busy           = r_busy;
  assign wb_err         = r_wb_err;
  assign almacenamiento = r_alm;

endmodule

// File: tb/tb_reg_info_bank.sv
// Directed self-checking bench for reg_info_bank with a short write-back timeout.
module tb_reg_info_bank;

  localparam int DW = 48;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          clr, estado, user_we, rtc_valid, wb_ack;
  logic [CW-1:0] ch_sel, disp_ch, rtc_ch;
  logic [DW-1:0] dato_user, dato_rtc;
  logic          wb_req, busy, wb_err;
  logic [CW-1:0] wb_ch;
  logic [DW-1:0] wb_data, almacenamiento;

  int n_tests = 0;
  int n_fail  = 0;

  reg_info_bank #(.DATA_W(DW), .N_CH(3), .CH_W(CW), .TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .estado(estado), .ch_sel(ch_sel), .disp_ch(disp_ch),
    .dato_user(dato_user), .user_we(user_we), .dato_rtc(dato_rtc), .rtc_ch(rtc_ch),
    .rtc_valid(rtc_valid), .wb_ack(wb_ack), .wb_req(wb_req), .wb_ch(wb_ch),
    .wb_data(wb_data), .busy(busy), .wb_err(wb_err), .almacenamiento(almacenamiento)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; estado = 1'b0; user_we = 1'b0; rtc_valid = 1'b0; wb_ack = 1'b0;
    ch_sel = 2'd0; disp_ch = 2'd0; rtc_ch = 2'd0; dato_user = 48'h0; dato_rtc = 48'h0;
    tick(); tick();
    clr = 1'b0;
    n_tests++; if (almacenamiento !== 48'h0) begin n_fail++; $display("FAIL reset_alm got %h exp 0", almacenamiento); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (wb_req !== 1'b0 || wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wb got req=%b err=%b exp 0/0", wb_req, wb_err); end
    n_tests++; if (wb_ch !== 2'd0 || wb_data !== 48'h0) begin n_fail++; $display("FAIL reset_wbdata got ch=%0d data=%h exp 0/0", wb_ch, wb_data); end
  endtask

  task automatic test_tracking();
    rtc_valid = 1'b1; rtc_ch = 2'd1; dato_rtc = 48'h0000_0012_3045;
    tick();
    rtc_valid = 1'b0;
    tick();
    n_tests++; if (almacenamiento !== 48'h0) begin n_fail++; $display("FAIL track_disp0 got %h exp 0", almacenamiento); end
    disp_ch = 2'd1;
    tick();
    n_tests++; if (almacenamiento !== 48'h0000_0012_3045) begin n_fail++; $display("FAIL track_disp1 got %h exp 000000123045", almacenamiento); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL track_busy got %b exp 0", busy); end
    // Out-of-range RTC channel is dropped and out-of-range display reads zero
    rtc_valid = 1'b1; rtc_ch = 2'd3; dato_rtc = 48'hFFFF_FFFF_FFFF;
    tick();
    rtc_valid = 1'b0; disp_ch = 2'd3;
    tick(); tick();
    n_tests++; if (almacenamiento !== 48'h0) begin n_fail++; $display("FAIL track_ch3 got %h exp 0", almacenamiento); end
  endtask

  task automatic test_edit_commit();
    estado = 1'b1; ch_sel = 2'd0;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL edit_busy got %b exp 1", busy); end
    user_we = 1'b1; dato_user = 48'h0000_0023_5959;
    tick();
    user_we = 1'b0; estado = 1'b0;
    tick();
    n_tests++; if (wb_req !== 1'b1 || wb_ch !== 2'd0) begin n_fail++; $display("FAIL commit_req got req=%b ch=%0d exp 1/0", wb_req, wb_ch); end
    n_tests++; if (wb_data !== 48'h0000_0023_5959) begin n_fail++; $display("FAIL commit_data got %h exp 000000235959", wb_data); end
    tick(); tick();
    n_tests++; if (wb_req !== 1'b1) begin n_fail++; $display("FAIL commit_hold got %b exp 1", wb_req); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_tests++; if (wb_req !== 1'b0 || busy !== 1'b0 || wb_err !== 1'b0) begin n_fail++; $display("FAIL commit_ack got req=%b busy=%b err=%b exp 0/0/0", wb_req, busy, wb_err); end
    disp_ch = 2'd0;
    tick();
    n_tests++; if (almacenamiento !== 48'h0000_0023_5959) begin n_fail++; $display("FAIL commit_bank got %h exp 000000235959", almacenamiento); end
  endtask

  task automatic test_edit_isolation();
    estado = 1'b1; ch_sel = 2'd0;
    tick();
    rtc_valid = 1'b1; rtc_ch = 2'd0; dato_rtc = 48'h1;
    tick();
    rtc_ch = 2'd2; dato_rtc = 48'h2;
    tick();
    rtc_valid = 1'b0; disp_ch = 2'd0;
    tick();
    n_tests++; if (almacenamiento !== 48'h0000_0023_5959) begin n_fail++; $display("FAIL iso_shadow got %h exp 000000235959", almacenamiento); end
    disp_ch = 2'd2;
    tick();
    n_tests++; if (almacenamiento !== 48'h2) begin n_fail++; $display("FAIL iso_ch2 got %h exp 2", almacenamiento); end
    // Same-cycle user and RTC write on the edited channel: user wins
    user_we = 1'b1; dato_user = 48'h0000_0011_1111;
    rtc_valid = 1'b1; rtc_ch = 2'd0; dato_rtc = 48'h9;
    tick();
    user_we = 1'b0; rtc_valid = 1'b0; estado = 1'b0;
    tick();
    n_tests++; if (wb_req !== 1'b1 || wb_data !== 48'h0000_0011_1111) begin n_fail++; $display("FAIL iso_commit got req=%b data=%h exp 1/000000111111", wb_req, wb_data); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0; disp_ch = 2'd0;
    n_tests++; if (wb_req !== 1'b0) begin n_fail++; $display("FAIL iso_first_ack got %b exp 0", wb_req); end
    tick();
    n_tests++; if (almacenamiento !== 48'h0000_0011_1111) begin n_fail++; $display("FAIL iso_bank got %h exp 000000111111", almacenamiento); end
  endtask

  task automatic test_no_change();
    estado = 1'b1; ch_sel = 2'd1;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nochg_enter got %b exp 1", busy); end
    estado = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0 || wb_req !== 1'b0) begin n_fail++; $display("FAIL nochg_exit got busy=%b req=%b exp 0/0", busy, wb_req); end
    disp_ch = 2'd1;
    tick();
    n_tests++; if (almacenamiento !== 48'h0000_0012_3045) begin n_fail++; $display("FAIL nochg_bank got %h exp 000000123045", almacenamiento); end
    estado = 1'b1; ch_sel = 2'd3;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_sel got %b exp 0", busy); end
    estado = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int hi;
    estado = 1'b1; ch_sel = 2'd2;
    tick();
    user_we = 1'b1; dato_user = 48'h0000_0000_0777;
    tick();
    user_we = 1'b0; estado = 1'b0;
    tick();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_req !== 1'b1) break;
      hi++;
      tick();
    end
    n_tests++; if (hi != 4) begin n_fail++; $display("FAIL tout_len got %0d exp 4", hi); end
    n_tests++; if (wb_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tout_err got err=%b busy=%b exp 1/0", wb_err, busy); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_tests++; if (wb_err !== 1'b1 || wb_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack got err=%b req=%b exp 1/0", wb_err, wb_req); end
    disp_ch = 2'd2;
    tick();
    n_tests++; if (almacenamiento !== 48'h0000_0000_0777) begin n_fail++; $display("FAIL tout_bank got %h exp 000000000777", almacenamiento); end
    estado = 1'b1;
    tick();
    user_we = 1'b1; dato_user = 48'h0000_0000_0888;
    tick();
    user_we = 1'b0; estado = 1'b0;
    tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_tests++; if (wb_err !== 1'b0 || wb_req !== 1'b0) begin n_fail++; $display("FAIL err_clear got err=%b req=%b exp 0/0", wb_err, wb_req); end
  endtask

  task automatic test_reset_mid_wb();
    estado = 1'b1; ch_sel = 2'd1;
    tick();
    user_we = 1'b1; dato_user = 48'h0000_0000_0ABC;
    tick();
    user_we = 1'b0; estado = 1'b0; disp_ch = 2'd1;
    tick();
    n_tests++; if (wb_req !== 1'b1 || wb_ch !== 2'd1) begin n_fail++; $display("FAIL mid_req got req=%b ch=%0d exp 1/1", wb_req, wb_ch); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++; if (wb_req !== 1'b0 || busy !== 1'b0 || wb_err !== 1'b0) begin n_fail++; $display("FAIL mid_clr got req=%b busy=%b err=%b exp 0/0/0", wb_req, busy, wb_err); end
    n_tests++; if (wb_ch !== 2'd0 || wb_data !== 48'h0 || almacenamiento !== 48'h0) begin n_fail++; $display("FAIL mid_clr_data got ch=%0d data=%h alm=%h exp 0", wb_ch, wb_data, almacenamiento); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_tests++; if (wb_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_late_ack got req=%b busy=%b exp 0/0", wb_req, busy); end
    disp_ch = 2'd0;
    tick();
    n_tests++; if (almacenamiento !== 48'h0) begin n_fail++; $display("FAIL mid_bank0 got %h exp 0", almacenamiento); end
  endtask

  initial begin
    test_reset();
    test_tracking();
    test_edit_commit();
    test_edit_isolation();
    test_no_change();
    test_timeout();
    test_reset_mid_wb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
